// File: rtl/ibex_register_file_mp.sv
// Flip-flop register file with two write ports (B wins on address clash), optional
// write-to-read bypass and a word-serial clear sequencer for the reset-less storage.
module ibex_rf_mp_rport #(
  parameter int unsigned NumWords          = 32,
  parameter int unsigned DataWidth         = 32,
  parameter bit          WriteBypass       = 1'b1,
  parameter bit          DummyInstructions = 1'b0,
  parameter logic [DataWidth-1:0] WordZeroVal = '0,
  localparam int unsigned AW = $clog2(NumWords)
) (
  input  logic [AW-1:0]                      raddr_i,
  input  logic [NumWords-1:0][DataWidth-1:0] mem_i,
  input  logic                               busy_i,
  input  logic                               dummy_id_i,
  input  logic                               we_a_i,
  input  logic [AW-1:0]                      waddr_a_i,
  input  logic [DataWidth-1:0]               wdata_a_i,
  input  logic                               we_b_i,
  input  logic [AW-1:0]                      waddr_b_i,
  input  logic [DataWidth-1:0]               wdata_b_i,
  output logic [DataWidth-1:0]               rdata_o
);
  // Later assignments override earlier ones: busy beats bypass beats storage.
  always_comb begin
    rdata_o = mem_i[raddr_i];
    if (raddr_i == '0 && !(DummyInstructions && dummy_id_i)) rdata_o = WordZeroVal;
    if (WriteBypass && raddr_i != '0) begin
      if (we_b_i && waddr_b_i == raddr_i)      rdata_o = wdata_b_i;
      else if (we_a_i && waddr_a_i == raddr_i) rdata_o = wdata_a_i;
    end
    if (busy_i) rdata_o = WordZeroVal;
  end
endmodule

module ibex_register_file_mp #(
  parameter int unsigned NumWords          = 32,
  parameter int unsigned DataWidth         = 32,
  parameter int unsigned NumReadPorts      = 2,
  parameter bit          WriteBypass       = 1'b1,
  parameter bit          DummyInstructions = 1'b0,
  parameter logic [DataWidth-1:0] WordZeroVal = '0
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              dummy_instr_id_i,
  input  logic                              dummy_instr_wb_i,
  input  logic [5*NumReadPorts-1:0]         raddr_i,
  output logic [DataWidth*NumReadPorts-1:0] rdata_o,
  input  logic [4:0]                        waddr_a_i,
  input  logic [DataWidth-1:0]              wdata_a_i,
  input  logic                              we_a_i,
  input  logic [4:0]                        waddr_b_i,
  input  logic [DataWidth-1:0]              wdata_b_i,
  input  logic                              we_b_i,
  input  logic                              clear_req_i,
  output logic                              busy_o,
  output logic                              collision_o,
  output logic [NumWords-1:0]               waddr_onehot_o
);
  localparam int unsigned AW = $clog2(NumWords);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e                             state_q, state_d;
  logic [AW-1:0]                      cnt_q, cnt_d;
  logic                               collision_q, collision_d;
  logic [NumWords-1:0][DataWidth-1:0] mem_q, mem_d;
  logic [AW-1:0]                      wa, wb;
  logic                               we_a_eff, we_b_eff, r0_we_a, r0_we_b;

  assign wa       = waddr_a_i[AW-1:0];
  assign wb       = waddr_b_i[AW-1:0];
  assign busy_o   = (state_q == CLEAR);
  assign we_a_eff = we_a_i & ~busy_o;
  assign we_b_eff = we_b_i & ~busy_o;
  assign r0_we_a  = DummyInstructions && dummy_instr_wb_i && we_a_eff && (wa == '0);
  assign r0_we_b  = DummyInstructions && dummy_instr_wb_i && we_b_eff && (wb == '0);

  assign collision_d = we_a_eff & we_b_eff & (wa == wb) & (wa != '0);
  assign collision_o = collision_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= CLEAR;
      cnt_q       <= AW'(1);
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      collision_q <= collision_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        if (cnt_q == AW'(NumWords - 1)) state_d = IDLE;
        else                            cnt_d   = cnt_q + AW'(1);
      end
      default: begin
        if (clear_req_i) begin
          state_d = CLEAR;
          cnt_d   = AW'(1);
        end
      end
    endcase
  end

  // Slot 0 only holds state when dummy instructions are enabled.
  always_comb begin
    mem_d = mem_q;
    for (int unsigned i = 1; i < NumWords; i++) begin
      if (busy_o && cnt_q == AW'(i))    mem_d[i] = WordZeroVal;
      else if (we_b_eff && wb == AW'(i)) mem_d[i] = wdata_b_i;
      else if (we_a_eff && wa == AW'(i)) mem_d[i] = wdata_a_i;
    end
    mem_d[0] = WordZeroVal;
    if (DummyInstructions) begin
      mem_d[0] = mem_q[0];
      if (busy_o)       mem_d[0] = WordZeroVal;
      else if (r0_we_b) mem_d[0] = wdata_b_i;
      else if (r0_we_a) mem_d[0] = wdata_a_i;
    end
  end

  always_ff @(posedge clk_i) mem_q <= mem_d;

  always_comb begin
    waddr_onehot_o = '0;
    for (int unsigned i = 1; i < NumWords; i++)
      waddr_onehot_o[i] = (we_a_eff && wa == AW'(i)) || (we_b_eff && wb == AW'(i));
    waddr_onehot_o[0] = r0_we_a | r0_we_b;
  end

  for (genvar p = 0; p < NumReadPorts; p++) begin : g_rd
    ibex_rf_mp_rport #(
      .NumWords(NumWords), .DataWidth(DataWidth), .WriteBypass(WriteBypass),
      .DummyInstructions(DummyInstructions), .WordZeroVal(WordZeroVal)
    ) u_rport (
      .raddr_i   (raddr_i[5*p +: AW]),
      .mem_i     (mem_q),
      .busy_i    (busy_o),
      .dummy_id_i(dummy_instr_id_i),
      .we_a_i    (we_a_eff),
      .waddr_a_i (wa),
      .wdata_a_i (wdata_a_i),
      .we_b_i    (we_b_eff),
      .waddr_b_i (wb),
      .wdata_b_i (wdata_b_i),
      .rdata_o   (rdata_o[DataWidth*p +: DataWidth])
    );
  end
endmodule

// File: tb/tb_ibex_register_file_mp.sv
// Two register-file configurations driven in lockstep against a word-level model;
// expectations are queued per cycle and checked by an independent monitor.
module tb_ibex_register_file_mp;
  localparam int NRP = 3;

  logic              clk = 1'b0;
  logic              rst_ni, dummy_id, dummy_wb, we_a, we_b, clear_req;
  logic [5*NRP-1:0]  raddr;
  logic [4:0]        waddr_a, waddr_b;
  logic [31:0]       wdata_a, wdata_b;
  logic [NRP*32-1:0] rd0, rd1;
  logic              busy0, busy1, coll0, coll1;
  logic [31:0]       oh0;
  logic [15:0]       oh1;

  always #5 clk = ~clk;

  ibex_register_file_mp #(
    .NumWords(32), .DataWidth(32), .NumReadPorts(NRP), .WriteBypass(1'b1),
    .DummyInstructions(1'b0), .WordZeroVal(32'h0)
  ) u0 (
    .clk_i(clk), .rst_ni(rst_ni), .dummy_instr_id_i(dummy_id), .dummy_instr_wb_i(dummy_wb),
    .raddr_i(raddr), .rdata_o(rd0), .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
    .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b), .clear_req_i(clear_req),
    .busy_o(busy0), .collision_o(coll0), .waddr_onehot_o(oh0)
  );

  ibex_register_file_mp #(
    .NumWords(16), .DataWidth(32), .NumReadPorts(NRP), .WriteBypass(1'b0),
    .DummyInstructions(1'b1), .WordZeroVal(32'h0)
  ) u1 (
    .clk_i(clk), .rst_ni(rst_ni), .dummy_instr_id_i(dummy_id), .dummy_instr_wb_i(dummy_wb),
    .raddr_i(raddr), .rdata_o(rd1), .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
    .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b), .clear_req_i(clear_req),
    .busy_o(busy1), .collision_o(coll1), .waddr_onehot_o(oh1)
  );

  typedef struct packed {
    logic [1:0]                busy;
    logic [1:0]                coll;
    logic [1:0][31:0]          oh;
    logic [1:0][NRP-1:0][31:0] rd;
  } exp_t;

  exp_t        q[$];
  int          nerr = 0, nchk = 0;

  // Model state: word contents, dummy R0, cycles of clear left, pending collision.
  logic [31:0] mm[2][32];
  logic [31:0] mr0[2];
  int          bl[2];
  logic        cq[2];

  function automatic int nw(int k);  return (k == 0) ? 32 : 16; endfunction
  function automatic bit byp(int k); return (k == 0);           endfunction
  function automatic bit dum(int k); return (k == 1);           endfunction

  task automatic cyc();
    exp_t        e;
    logic [4:0]  msk, a, b, ra;
    logic        bz, ea, eb;
    logic [31:0] v;
    e = '0;
    for (int k = 0; k < 2; k++) begin
      msk = (k == 0) ? 5'h1f : 5'h0f;
      a   = waddr_a & msk;
      b   = waddr_b & msk;
      bz  = !rst_ni || bl[k] > 0;
      ea  = we_a && !bz;
      eb  = we_b && !bz;
      e.busy[k] = bz;
      e.coll[k] = rst_ni && cq[k];
      if (ea && a != 0) e.oh[k][a] = 1'b1;
      if (eb && b != 0) e.oh[k][b] = 1'b1;
      if (dum(k) && dummy_wb && ((ea && a == 0) || (eb && b == 0))) e.oh[k][0] = 1'b1;
      for (int p = 0; p < NRP; p++) begin
        ra = raddr[5*p +: 5] & msk;
        if (bz)                                   v = 32'h0;
        else if (byp(k) && ra != 0 && eb && b == ra) v = wdata_b;
        else if (byp(k) && ra != 0 && ea && a == ra) v = wdata_a;
        else if (ra == 0)                         v = (dum(k) && dummy_id) ? mr0[k] : 32'h0;
        else                                      v = mm[k][ra];
        e.rd[k][p] = v;
      end
      if (!rst_ni) begin
        bl[k] = nw(k) - 1;
        cq[k] = 1'b0;
      end else begin
        cq[k] = ea && eb && a == b && a != 0;
        if (ea) begin
          if (a != 0) mm[k][a] = wdata_a;
          else if (dum(k) && dummy_wb) mr0[k] = wdata_a;
        end
        if (eb) begin
          if (b != 0) mm[k][b] = wdata_b;
          else if (dum(k) && dummy_wb) mr0[k] = wdata_b;
        end
        if (bl[k] > 0) begin
          bl[k]--;
          if (bl[k] == 0) begin
            for (int i = 0; i < 32; i++) mm[k][i] = 32'h0;
            mr0[k] = 32'h0;
          end
        end else if (clear_req) bl[k] = nw(k) - 1;
      end
    end
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  exp_t me;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      me = q.pop_front();
      chk("busy0", {31'b0, busy0}, {31'b0, me.busy[0]});
      chk("busy1", {31'b0, busy1}, {31'b0, me.busy[1]});
      chk("coll0", {31'b0, coll0}, {31'b0, me.coll[0]});
      chk("coll1", {31'b0, coll1}, {31'b0, me.coll[1]});
      chk("onehot0", oh0, me.oh[0]);
      chk("onehot1", {16'b0, oh1}, me.oh[1]);
      for (int p = 0; p < NRP; p++) begin
        chk($sformatf("rdata0[%0d]", p), rd0[32*p +: 32], me.rd[0][p]);
        chk($sformatf("rdata1[%0d]", p), rd1[32*p +: 32], me.rd[1][p]);
      end
    end
  end

  task automatic set_idle();
    dummy_id = 0; dummy_wb = 0; we_a = 0; we_b = 0; clear_req = 0;
    waddr_a = 0; waddr_b = 0; wdata_a = 0; wdata_b = 0; raddr = '0;
  endtask

  task automatic rd3(logic [4:0] r2, logic [4:0] r1, logic [4:0] r0);
    raddr = {r2, r1, r0};
  endtask

  function automatic logic [4:0] pick();
    case ($urandom % 8)
      0: return 5'd0;
      1: return 5'd1;
      2: return 5'd7;
      3: return 5'd17;
      4: return 5'd31;
      default: return 5'($urandom % 32);
    endcase
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      bl[k] = 0; cq[k] = 0; mr0[k] = 0;
      for (int i = 0; i < 32; i++) mm[k][i] = 0;
    end
    set_idle();
    rst_ni = 0;
    @(posedge clk); #1;
    repeat (3) cyc();
    rst_ni = 1;
    // Writes during the initial clear must be dropped.
    for (int i = 0; i < 10; i++) begin
      we_a = 1; waddr_a = 5'd3; wdata_a = $urandom; rd3(5'd3, 5'd3, pick());
      cyc();
    end
    we_a = 0;
    repeat (25) cyc();
    for (int r = 0; r < 32; r++) begin rd3(5'(r), 5'(r), 5'(r)); cyc(); end
    // Same-cycle and next-cycle read of a fresh write.
    we_a = 1; waddr_a = 5'd5; wdata_a = 32'hDEADBEEF; rd3(5'd5, 5'd5, 5'd5); cyc();
    we_a = 0; cyc();
    // Colliding writes to x7, then to x0.
    we_a = 1; we_b = 1; waddr_a = 5'd7; waddr_b = 5'd7; wdata_a = 32'h11; wdata_b = 32'h22;
    rd3(5'd7, 5'd7, 5'd0); cyc();
    we_a = 0; we_b = 0; repeat (3) cyc();
    we_a = 1; we_b = 1; waddr_a = 5'd0; waddr_b = 5'd0; rd3(5'd0, 5'd0, 5'd0); cyc();
    we_a = 0; we_b = 0; repeat (2) cyc();
    // Aliasing in the 16-word instance.
    we_a = 1; waddr_a = 5'd17; wdata_a = 32'h55; rd3(5'd17, 5'd1, 5'd0); cyc();
    we_a = 0; cyc();
    // Dummy R0 write and reads with dummy_id both ways.
    we_a = 1; waddr_a = 5'd0; wdata_a = 32'hAA; dummy_wb = 1; rd3(5'd0, 5'd0, 5'd0); cyc();
    we_a = 0; dummy_wb = 0; dummy_id = 1; cyc();
    dummy_id = 0; cyc();
    dummy_id = 1; cyc();
    dummy_id = 0;
    // Fill, clear, reset mid-clear, then read everything back.
    for (int i = 1; i < 32; i++) begin
      we_a = 1; waddr_a = 5'(i); wdata_a = 32'h01010101 * i; rd3(5'(i), pick(), pick()); cyc();
    end
    we_a = 0; clear_req = 1; cyc();
    clear_req = 0; repeat (10) cyc();
    rst_ni = 0; repeat (2) cyc();
    rst_ni = 1;
    for (int i = 0; i < 33; i++) begin
      clear_req = (i == 5); rd3(pick(), pick(), pick()); cyc();
    end
    clear_req = 0;
    for (int r = 0; r < 32; r++) begin rd3(5'(r), 5'(31 - r), 5'(r)); cyc(); end
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst_ni    = ($urandom % 600) != 0;
      clear_req = ($urandom % 90) == 0;
      dummy_id  = $urandom; dummy_wb = $urandom;
      we_a      = $urandom; we_b = $urandom;
      waddr_a   = pick(); waddr_b = pick();
      wdata_a   = $urandom; wdata_b = $urandom;
      rd3(pick(), pick(), pick());
      cyc();
    end
    set_idle(); rst_ni = 1;
    repeat (2) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/ibex_register_file_mp.md
# ibex_register_file_mp

Flip-flop based, multi-port successor to the single-write-port latch register file. It provides a configurable depth (16 or 32 words), width, and number of read ports, with two write ports. It also adds:
- a fixed write-port priority with collision reporting,
- optional same-cycle write-to-read bypass,
- a word-serial clear sequencer that initialises the reset-less storage.

It sits in the ID stage and serves operand reads, with write-back from the WB stage and a second write port for load/dual-issue return.

## Interface
Parameters:
- NumWords, 32, number of architectural registers; legal values are 16 or 32.
- DataWidth, 32, width of each word.
- NumReadPorts, 2, number of read ports; range 1..4.
- WriteBypass, 1, when 1, a read of a word being written this cycle returns the incoming write data.
- DummyInstructions, 0, when 1, R0 is a real storage word that is visible only to dummy instructions.
- WordZeroVal, '0, value R0 reads as, and the value the clear sequencer writes.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- dummy_instr_id_i  in  1  the instruction in ID is a dummy instruction.
- dummy_instr_wb_i  in  1  the instruction in WB is a dummy instruction.
- raddr_i  in  5*NumReadPorts  read addresses; port p uses bits [5p+4:5p].
- rdata_o  out  DataWidth*NumReadPorts  read data; port p uses slice p.
- waddr_a_i, wdata_a_i, we_a_i  in  5 / DataWidth / 1  write port A.
- waddr_b_i, wdata_b_i, we_b_i  in  5 / DataWidth / 1  write port B.
- clear_req_i  in  1  request a full re-initialisation of the register contents.
- busy_o  out  1  clear sequence in progress.
- collision_o  out  1  registered one-cycle pulse: both ports wrote the same nonzero address.
- waddr_onehot_o  out  NumWords  combinational one-hot of all effective writes this cycle.

## Operation
- Addressing:
  - Only the low $clog2(NumWords) address bits are used; when NumWords=16, bit 4 is ignored.
  - The internal address width is $clog2(NumWords).
- Storage:
  - Words 1..NumWords-1 are flops without reset.
  - The content of every word is defined only by writes and by the clear sequencer.
- R0:
  - Writes to address 0 are dropped.
  - Reads of address 0 return WordZeroVal.
  - With DummyInstructions=1, a separate mem_r0 flop is written when an effective write targets address 0 and dummy_instr_wb_i=1. Reads of address 0 then return mem_r0 while dummy_instr_id_i=1.
- Effective write enables:
  - we_a_eff = we_a_i & !busy_o; we_b_eff = we_b_i & !busy_o.
  - Writes that arrive during a clear are discarded.
- Write priority: if both ports write the same address, port B's data is stored.
- Collision detection:
  - Condition: both effective enables, equal internal addresses, address ≠ 0.
  - The condition is registered into collision_o for exactly one cycle.
  - Address 0 never raises a collision.
- waddr_onehot_o:
  - Bit i is set when an effective write from A or B targets word i, for i ≥ 1.
  - Bit 0 is set only for a dummy R0 write when DummyInstructions=1; otherwise bit 0 is always 0.
- Reads are combinational. For each port, in priority order:
  1. busy_o=1: return WordZeroVal.
  2. WriteBypass=1 and the port reads a nonzero address being effectively written: return wdata_b_i if B hits, else wdata_a_i.
  3. Otherwise: return the stored word.
- Clear sequencer FSM, states IDLE and CLEAR, with counter cnt of width $clog2(NumWords):
  - Reset: state=CLEAR, cnt=1.
  - In CLEAR, each cycle: mem[cnt] <= WordZeroVal and mem_r0 <= WordZeroVal. If cnt==NumWords-1, go to IDLE; else cnt++.
  - In IDLE with clear_req_i=1: go to CLEAR, cnt=1. clear_req_i during CLEAR is ignored and does not restart the sequence.
  - busy_o = (state==CLEAR).
- Reset asserted mid-clear or mid-write: the FSM returns to CLEAR with cnt=1, and the full sequence reruns.

## Timing
- Output values during reset:
  - busy_o=1 and collision_o=0.
  - rdata_o = WordZeroVal on all ports, because busy_o=1.
  - waddr_onehot_o=0, because the effective enables are gated by busy_o.
- After reset release, busy_o stays high for NumWords-1 rising edges. The first write is accepted on the edge after busy_o falls.
- A clear_req_i sampled high in IDLE makes busy_o high from the next cycle, for NumWords-1 cycles.
- Write latency: data is stored on the write edge. It is readable from storage in the next cycle, and in the same cycle via bypass if WriteBypass=1.
- collision_o rises one cycle after the colliding write and is high for one cycle per colliding cycle.

## Test plan
- Reset with NumWords=32 and no requests → busy_o high for 31 cycles; then every read returns 0; a write with we_a_i=1 while busy_o=1 leaves the word at 0.
- Write A to x5=0xDEADBEEF, then read x5 on every port the next cycle → every port returns 0xDEADBEEF. With WriteBypass=1, the same-cycle read also returns 0xDEADBEEF; with WriteBypass=0, it returns the old value.
- A and B both write x7 (A=0x11, B=0x22) → x7 reads 0x22; collision_o=1 for exactly one cycle, one cycle later. The same test on x0 → no collision, and x0 reads 0.
- NumWords=16: write x17=0x55 → x1 reads 0x55; waddr_onehot_o bit 1 is set.
- DummyInstructions=1: a write to x0=0xAA with dummy_instr_wb_i=1 → x0 reads 0xAA when dummy_instr_id_i=1 and 0 otherwise.
- Fill x1..x31 with nonzero data, pulse clear_req_i, then assert rst_ni low mid-sequence → busy_o stays high, the sequence restarts at cnt=1, and after 31 cycles all words read 0.
